wb_timer_slave: RTL and testbench
=================================

Name: wb_timer_slave

Overview:
Wishbone classic slave timer/compare peripheral on the mips_sopc data bus; the CPU is the bus initiator and this block is the responder. It provides a prescaled 32-bit up-counter, a compare register, a sticky match flag and a level interrupt to the CPU interrupt input. Directed programs running on the SoC use it for delays and periodic interrupts.

Parameters:
PRESCALE, 4, counter ticks once every PRESCALE clk cycles; legal range 1..65535.
COMPARE_RST, 32'hFFFF_FFFF, reset value of COMPARE.

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  asynchronous, active-high reset (RstEnable = 1)
wb_cyc_i  input  1  bus cycle valid
wb_stb_i  input  1  strobe
wb_we_i  input  1  1 = write, 0 = read
wb_adr_i  input  32  byte address; only [3:2] decoded
wb_sel_i  input  4  byte enables for writes
wb_dat_i  input  32  write data
wb_dat_o  output  32  read data, valid while wb_ack_o = 1
wb_ack_o  output  1  single-cycle acknowledge
irq_o  output  1  registered level interrupt

Behaviour:
- Reset (asynchronous, while rst = 1): CTRL = 0, COUNT = 0, COMPARE = COMPARE_RST, MATCH = 0, prescaler = 0, wb_ack_o = 0, wb_dat_o = 0, irq_o = 0. Reset asserted mid-transaction aborts it; no ack is issued for that transaction.
- Register map, selected by adr[3:2]:
  - 0 CTRL: [0] EN, [1] AUTO_RELOAD, [2] IE; other bits read 0.
  - 1 COUNT: read/write.
  - 2 COMPARE: read/write.
  - 3 STATUS: [0] MATCH, write-1-to-clear.
- Bus handshake:
  - At an edge with cyc & stb = 1 and wb_ack_o = 0: register wb_ack_o = 1 and wb_dat_o = the addressed register value. The write takes effect at the same edge. Latency is 1 cycle.
  - At the next edge wb_ack_o returns to 0, so a held strobe is acked every other cycle.
  - wb_dat_o is 0 when not acking.
  - Writes honour wb_sel_i per byte. A write with sel = 0 still acks and changes nothing.
- Prescaler: counts 0..PRESCALE-1 while EN = 1. tick = 1 in the cycle it equals PRESCALE-1, then it wraps to 0. It holds its value while EN = 0. Writing CTRL does not reset it.
- Counter, on tick:
  - If COUNT == COMPARE: MATCH <= 1, and COUNT <= 0 if AUTO_RELOAD, else COUNT + 1.
  - Otherwise COUNT <= COUNT + 1, wrapping from FFFF_FFFF to 0 with no flag.
- irq_o <= MATCH & IE, one cycle after either bit changes.
- Simultaneous events:
  - CPU write to COUNT and a tick at the same edge: the write wins, and the compare for that tick is suppressed.
  - W1C of MATCH and a new match at the same edge: set wins, MATCH stays 1.
  - CPU write to COMPARE at a tick edge: the compare uses the old COMPARE.
- Reads return register values from before the edge (no bypass).
- Unused address bits are ignored, so the block aliases across its decoded window.

Test Plan:
1. Reset, then read all four registers -> CTRL 0, COUNT 0, COMPARE FFFF_FFFF, STATUS 0; every ack is exactly one cycle wide, one cycle after stb; irq_o 0.
2. PRESCALE = 4: write COMPARE = 5, then CTRL = 0x7 -> MATCH and irq_o rise one cycle apart once COUNT reaches 5 (24 clk after EN); COUNT reloads to 0 and rematches every 24 clk.
3. CTRL = 0x1, COMPARE = 3: COUNT reaches 3 -> MATCH = 1, irq_o stays 0 (IE = 0), COUNT continues to 4. Write STATUS = 1 -> MATCH 0. Issue W1C at the same edge as a match -> MATCH stays 1.
4. Write COUNT = FFFF_FFFE with EN = 1 and COMPARE = 10 -> COUNT wraps to 0 after 2 ticks with no MATCH. Write COUNT at a tick edge -> the written value is held and not incremented.
5. Byte-lane write to COMPARE: sel = 4'b0010, dat = 0x0000_AB00 from FFFF_FFFF -> COMPARE = FFFF_ABFF.
6. Hold stb high for 6 cycles -> exactly 3 acks. Assert rst mid-read -> wb_ack_o drops immediately and all registers return to reset values.

Source files
------------

// File: rtl/wb_timer_slave.sv
// wb_timer_slave: Wishbone classic timer/compare slave with prescaler, sticky match and level irq
module wb_timer_slave #(
  parameter int          PRESCALE    = 4,
  parameter logic [31:0] COMPARE_RST = 32'hFFFF_FFFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  input  logic        wb_we_i,
  input  logic [31:0] wb_adr_i,
  input  logic [3:0]  wb_sel_i,
  input  logic [31:0] wb_dat_i,
  output logic [31:0] wb_dat_o,
  output logic        wb_ack_o,
  output logic        irq_o
);
  logic [2:0]  ctrl;
  logic [31:0] count, compare, rdata;
  logic [15:0] pre;
  logic        match, hit, wr, wr_count, tick, eq, w1c;
  logic [1:0]  a;
  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] s);
    merge = old;
    for (int i = 0; i < 4; i++) if (s[i]) merge[8*i +: 8] = d[8*i +: 8];
  endfunction
  assign a        = wb_adr_i[3:2];
  assign hit      = wb_cyc_i & wb_stb_i & ~wb_ack_o;
  assign wr       = hit & wb_we_i;
  assign wr_count = wr && a == 2'd1;
  assign tick     = ctrl[0] && pre == 16'(PRESCALE - 1);
  // a CPU write to COUNT at a tick edge suppresses that tick's compare
  assign eq       = tick && count == compare && !wr_count;
  assign w1c      = wr && a == 2'd3 && wb_sel_i[0] && wb_dat_i[0];
  always_comb begin
    rdata = a == 2'd0 ? {29'd0, ctrl} : a == 2'd1 ? count : a == 2'd2 ? compare : {31'd0, match};
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctrl     <= '0;
      count    <= '0;
      compare  <= COMPARE_RST;
      match    <= 1'b0;
      pre      <= '0;
      wb_ack_o <= 1'b0;
      wb_dat_o <= '0;
      irq_o    <= 1'b0;
    end else begin
      wb_ack_o <= hit;
      wb_dat_o <= hit ? rdata : 32'd0;
      irq_o    <= match & ctrl[2];
      if (ctrl[0]) pre <= tick ? 16'd0 : pre + 16'd1;
      if (wr && a == 2'd0 && wb_sel_i[0]) ctrl <= wb_dat_i[2:0];
      if (wr && a == 2'd2) compare <= merge(compare, wb_dat_i, wb_sel_i);
      if (wr_count) count <= merge(count, wb_dat_i, wb_sel_i);
      else if (tick) count <= (eq && ctrl[1]) ? 32'd0 : count + 32'd1;
      match <= eq | (match & ~w1c);
    end
  end
endmodule

// File: tb/tb_wb_timer_slave.sv
// tb_wb_timer_slave: directed plus randomized bus traffic checked against a behavioural timer model
module tb_wb_timer_slave;
  localparam int P = 4;
  logic        clk = 0, rst = 1, cyc = 0, stb = 0, we = 0;
  logic [31:0] adr = 0, dat = 0;
  logic [3:0]  sel = 0;
  logic [31:0] dat_o;
  logic        ack, irq;
  logic [2:0]  m_ctrl;
  logic [31:0] m_count, m_cmp, m_dat, r;
  logic        m_match, m_irq, m_ack;
  int          m_pre, n_chk = 0, n_fail = 0, k, acks;

  wb_timer_slave #(.PRESCALE(P), .COMPARE_RST(32'hFFFF_FFFF)) dut (
    .clk(clk), .rst(rst), .wb_cyc_i(cyc), .wb_stb_i(stb), .wb_we_i(we), .wb_adr_i(adr),
    .wb_sel_i(sel), .wb_dat_i(dat), .wb_dat_o(dat_o), .wb_ack_o(ack), .irq_o(irq));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] lanes(input logic [31:0] old, input logic [31:0] d, input logic [3:0] s);
    lanes = old;
    for (int i = 0; i < 4; i++) if (s[i]) lanes[8*i +: 8] = d[8*i +: 8];
  endfunction

  task automatic model_reset();
    m_ctrl = 0; m_count = 0; m_cmp = 32'hFFFF_FFFF; m_match = 0; m_irq = 0;
    m_ack = 0; m_dat = 0; m_pre = 0;
  endtask

  task automatic model_edge();
    logic hit, w, tick, eq;
    int a;
    logic [31:0] rd;
    hit = cyc && stb && !m_ack;
    w = hit && we;
    a = int'(adr[3:2]);
    tick = m_ctrl[0] && m_pre == P - 1;
    eq = tick && m_count == m_cmp && !(w && a == 1);
    case (a)
      0: rd = {29'd0, m_ctrl};
      1: rd = m_count;
      2: rd = m_cmp;
      default: rd = {31'd0, m_match};
    endcase
    m_irq = m_match && m_ctrl[2];
    if (w && a == 1) m_count = lanes(m_count, dat, sel);
    else if (tick) m_count = (eq && m_ctrl[1]) ? 0 : m_count + 1;
    if (eq) m_match = 1;
    else if (w && a == 3 && sel[0] && dat[0]) m_match = 0;
    if (w && a == 2) m_cmp = lanes(m_cmp, dat, sel);
    if (m_ctrl[0]) m_pre = (m_pre + 1) % P;
    if (w && a == 0 && sel[0]) m_ctrl = dat[2:0];
    m_ack = hit;
    m_dat = hit ? rd : 0;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    chk("ack", {31'd0, ack}, {31'd0, m_ack});
    chk("dat_o", dat_o, m_dat);
    chk("irq", {31'd0, irq}, {31'd0, m_irq});
  endtask

  task automatic bus(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                     output logic [31:0] q);
    cyc = 1; stb = 1; we = w; adr = a; dat = d; sel = s;
    step();
    chk("ack_rise", {31'd0, ack}, 32'd1);
    q = dat_o;
    cyc = 0; stb = 0; we = 0;
    step();
    chk("ack_one_cycle", {31'd0, ack}, 32'd0);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    logic [31:0] q;
    bus(1, a, d, 4'hF, q);
  endtask

  task automatic rd_exp(input string tag, input logic [31:0] a, input logic [31:0] exp);
    logic [31:0] q;
    bus(0, a, 0, 4'h0, q);
    chk(tag, q, exp);
  endtask

  task automatic do_reset();
    rst = 1;
    cyc = 0; stb = 0; we = 0;
    repeat (2) @(posedge clk);
    model_reset();
    #1;
    chk("rst_ack", {31'd0, ack}, 32'd0);
    chk("rst_irq", {31'd0, irq}, 32'd0);
    @(negedge clk) rst = 0;
  endtask

  task automatic wait_tick(input logic need_eq);
    for (k = 0; k < 200; k++) begin
      if (m_ctrl[0] && m_pre == P - 1 && (!need_eq || m_count == m_cmp)) break;
      step();
    end
    chk("wait_tick_bound", {31'd0, k < 200}, 32'd1);
  endtask

  initial begin
    do_reset();
    rd_exp("rst_ctrl", 32'h0, 0);
    rd_exp("rst_count", 32'h4, 0);
    rd_exp("rst_compare", 32'h8, 32'hFFFF_FFFF);
    rd_exp("rst_status", 32'hC, 0);

    wr(32'h8, 5);
    wr(32'h0, 7);
    k = 1;
    while (!irq && k < 200) begin step(); k++; end
    chk("irq_latency", k, 25);
    rd_exp("match_set", 32'hC, 1);
    wr(32'hC, 1);
    repeat (60) step();

    do_reset();
    wr(32'h8, 3);
    wr(32'h0, 1);
    for (k = 0; k < 200 && !m_match; k++) step();
    repeat (8) step();
    chk("irq_masked", {31'd0, irq}, 32'd0);
    rd_exp("match_noie", 32'hC, 1);
    wr(32'hC, 1);
    rd_exp("w1c_clear", 32'hC, 0);
    do begin wr(32'h4, 3); end while (m_count != 3);
    wait_tick(1);
    wr(32'hC, 1);
    rd_exp("set_beats_w1c", 32'hC, 1);

    wr(32'hC, 1);
    wr(32'h8, 10);
    wr(32'h4, 32'hFFFF_FFFE);
    for (k = 0; k < 200 && m_count != 0; k++) step();
    rd_exp("wrap_nomatch", 32'hC, 0);
    wait_tick(0);
    wr(32'h4, 100);
    rd_exp("count_write_wins", 32'h4, 100);

    do_reset();
    begin
      logic [31:0] q;
      bus(1, 32'h8, 32'h0000_AB00, 4'b0010, q);
      rd_exp("byte_lane", 32'h8, 32'hFFFF_ABFF);
      bus(1, 32'h8, 32'h1234_5678, 4'b0000, q);
      rd_exp("sel_zero", 32'h8, 32'hFFFF_ABFF);
      rd_exp("alias", 32'hFFF0_0018, 32'hFFFF_ABFF);
    end

    cyc = 1; stb = 1; we = 0; adr = 32'h4; acks = 0;
    repeat (6) begin step(); acks += int'(ack); end
    cyc = 0; stb = 0;
    step();
    chk("held_stb_acks", acks, 3);

    wr(32'h0, 7);
    wr(32'h8, 2);
    cyc = 1; stb = 1; adr = 32'h8;
    step();
    #2 rst = 1;
    #1;
    chk("rst_abort_ack", {31'd0, ack}, 32'd0);
    chk("rst_abort_dat", dat_o, 0);
    do_reset();
    rd_exp("rst2_ctrl", 32'h0, 0);
    rd_exp("rst2_compare", 32'h8, 32'hFFFF_FFFF);

    wr(32'h8, 20);
    wr(32'h0, 7);
    for (int i = 0; i < 150; i++) begin
      logic [31:0] q, d, a;
      a = $urandom_range(0, 3);
      d = (a == 0) ? ($urandom & 7) | 1 : ($urandom % 2) ? $urandom_range(0, 40) : $urandom;
      bus($urandom % 2, ($urandom & 32'hFFFF_FFF0) | (a << 2), d, 4'($urandom), q);
      repeat ($urandom_range(0, 6)) step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
